act_requant_q35: RTL and testbench
==================================

# act_requant_q35

Streaming requantization stage that sits directly upstream of the piecewise-linear sigmoid unit. It takes wide signed accumulator results from the MAC array and adds a per-stream bias. It then rounds and arithmetically right-shifts the sum, saturates it to the signed 8-bit Q3.5 range (−4.0 to +3.96875), and presents it on a valid/ready stream whose data drives the sigmoid's `x_in`. It is a two-stage pipeline with full backpressure support and a saturation-event counter for range tuning.

## Interface
Parameters:
- `ACC_W`, default 24: accumulator/bias width, signed.
- `CNT_W`, default 16: saturation counter width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: stage can accept a beat.
- `in_acc`, in, ACC_W: signed accumulator value.
- `in_last`, in, 1: last beat of vector; passed through aligned with data.
- `cfg_shift`, in, 5: right-shift amount; sampled with each accepted beat.
- `cfg_bias`, in, ACC_W: signed bias; sampled with each accepted beat.
- `sat_clr`, in, 1: synchronous clear of `sat_count`.
- `out_valid`, out, 1: output beat valid.
- `out_ready`, in, 1: downstream accepts beat.
- `out_x`, out, 8: signed Q3.5 result.
- `out_last`, out, 1: aligned `in_last`.
- `sat_count`, out, CNT_W: count of saturated beats, sticky at all-ones.

## Operation
- Accept occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Stage 1 registers `sum = in_acc + cfg_bias` at ACC_W+1 bits (no overflow), `last`, and the effective shift `sh = min(cfg_shift, 16)`.
- Stage 2 computes `r = (sum + (sh ? 1<<(sh−1) : 0)) >>> sh` at ACC_W+2 bits. Rounding is round-half-up, toward +∞: −1.5 gives −1 and +1.5 gives 2.
- Saturation: r > 127 gives 127; r < −128 gives −128; otherwise `out_x = r[7:0]`.
- A beat is flagged saturated only if r lies strictly outside [−128, 127]. Exactly −128 or 127 is not flagged.
- `sat_count` increments by 1 when a flagged beat loads into stage 2. It holds at 2^CNT_W−1.
- `sat_clr` has priority over a same-cycle increment, so the result is 0.
- Config changes affect only beats accepted after the change. In-flight beats keep their sampled shift and bias.
- Beats are never dropped, duplicated, or reordered.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `out_valid`=0, `out_x`=0, `out_last`=0, `sat_count`=0, both stage valid flags 0.
  - All in-flight beats are discarded.
  - `in_ready`=0 while `reset` is low.
- Pipeline advance rules:
  - Stage 2 loads when `!s2_valid || out_ready`.
  - Stage 1 loads when `!s1_valid || s2_load`.
  - `in_ready = reset && (!s1_valid || s2_load)`. This is combinational from `out_ready`.
- Latency: a beat accepted on edge N appears on `out_valid`/`out_x` after edge N+2 (2 cycles), with no stall.
- Throughput: 1 beat per cycle when `out_ready` is held high.
- While `out_valid && !out_ready`, `out_x` and `out_last` are held stable.
- With `out_ready` low, exactly 2 beats are absorbed (one per stage) before `in_ready` drops.
- Accept and output transfer in the same cycle are fully supported at both stages.

## Structure
- Shared package `act_pkg`:
  - Q3.5 width constant (8) and frac bits (5).
  - `Q35_MAX`=127 and `Q35_MIN`=−128.
  - `SHIFT_MAX`=16.
  - Default `ACC_W`=24.
  - Shared with the sigmoid stage and other activation blocks.
- One sub-module, `requant_round_sat`: a combinational round, shift, saturate unit producing `out_x` and the saturation flag. It is instantiated in stage 2.
- The handshake/pipeline control and the counter stay in the top module.

## Test plan
- Rounding: shift=6, bias=0, acc = 640, 96, −96, 32, −32 → out_x = 10, 2, −1, 1, 0; `sat_count` stays 0.
- Saturation: shift=6, acc = 100000, −100000, −8192, 8128 → 127, −128, −128, 127; `sat_count`=2. Then `sat_clr` on the same cycle as a further saturating beat → `sat_count`=0.
- Shift/bias edges:
  - shift=0, acc=−3 → −3.
  - shift=20, acc=0x7FFFFF → clamped to shift 16 → 127, i.e. r = 128 (saturated).
  - bias=−640, acc=640, shift=6 → 0.
- Latency/throughput: out_ready=1, 8 back-to-back beats acc=k·32 with shift=5, k=0..7 → first `out_valid` 2 cycles after first accept, 8 consecutive valid cycles with out_x=0..7, `out_last` only on the 8th.
- Backpressure: out_ready=0 for 6 cycles while in_valid streams → exactly 2 accepts, then in_ready=0 and `out_x` stable. Then random out_ready toggling → all beats delivered in order, none lost or duplicated.
- Reset mid-stream: assert reset with 2 beats in flight → `out_valid`=0 immediately and in_ready=0. After release, no stale beat appears, and the first new beat emerges 2 cycles after its accept.

Source files
------------

// File: rtl/act_pkg.sv
// Shared constants for the activation datapath (requant, sigmoid and friends).
package act_pkg;

  // Q3.5 activation format.
  localparam int Q35_W     = 8;
  localparam int Q35_FRAC  = 5;
  localparam int Q35_MAX   = 127;
  localparam int Q35_MIN   = -128;

  // Largest right shift the requant stage will honour.
  localparam int SHIFT_MAX = 16;

  // Default accumulator / bias width coming from the MAC array.
  localparam int ACC_W_DEF = 24;

  // Clamp a requested shift to SHIFT_MAX.
  function automatic logic [4:0] eff_shift(input logic [4:0] sh);
    logic [4:0] res;
    if (sh > 5'(SHIFT_MAX)) begin
      res = 5'(SHIFT_MAX);
    end else begin
      res = sh;
    end
    return res;
  endfunction

endpackage

// File: rtl/requant_round_sat.sv
// Combinational round-half-up, arithmetic right shift and Q3.5 saturation.
module requant_round_sat
  import act_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W:0] sum,
  input  logic [4:0]     sh,
  output logic [7:0]     x,
  output logic           sat
);

  localparam int RW = ACC_W + 2;
  localparam logic signed [RW-1:0] ONE_C   = RW'(1);
  localparam logic signed [RW-1:0] R_MAX_C = RW'(Q35_MAX);
  localparam logic signed [RW-1:0] R_MIN_C = RW'(Q35_MIN);

  logic signed [RW-1:0] sum_ext_s;
  logic signed [RW-1:0] rnd_s;
  logic signed [RW-1:0] r_s;

  // Add half an LSB of the result, shift arithmetically, then clamp to Q3.5.
  always_comb begin
    sum_ext_s = {sum[ACC_W], sum};
    if (sh != 5'd0) begin
      rnd_s = ONE_C <<< (sh - 5'd1);
    end else begin
      rnd_s = '0;
    end
    r_s = (sum_ext_s + rnd_s) >>> sh;
    if (r_s > R_MAX_C) begin
      x   = 8'h7F;
      sat = 1'b1;
    end else if (r_s < R_MIN_C) begin
      x   = 8'h80;
      sat = 1'b1;
    end else begin
      x   = r_s[7:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/act_requant_q35.sv
// Two-stage requantization pipeline: bias add, then round/shift/saturate to Q3.5.
module act_requant_q35
  import act_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_acc,
  input  logic             in_last,
  input  logic [4:0]       cfg_shift,
  input  logic [ACC_W-1:0] cfg_bias,
  input  logic             sat_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_x,
  output logic             out_last,
  output logic [CNT_W-1:0] sat_count
);

  logic             s1_valid_r;
  logic [ACC_W:0]   s1_sum_r;
  logic [4:0]       s1_sh_r;
  logic             s1_last_r;
  logic             s2_valid_r;

  logic             s2_load_s;
  logic             s1_load_s;
  logic             accept_s;
  logic [ACC_W:0]   sum_s;
  logic [7:0]       rs_x_s;
  logic             rs_sat_s;
  logic             sat_inc_s;

  // Handshake: each stage refills when it is empty or its content moves on.
  always_comb begin
    s2_load_s = !s2_valid_r || out_ready;
    s1_load_s = !s1_valid_r || s2_load_s;
    in_ready  = reset && s1_load_s;
    accept_s  = in_valid && in_ready;
    sum_s     = {in_acc[ACC_W-1], in_acc} + {cfg_bias[ACC_W-1], cfg_bias};
    sat_inc_s = s2_load_s && s1_valid_r && rs_sat_s;
  end

  assign out_valid = s2_valid_r;

  requant_round_sat #(.ACC_W(ACC_W)) u_round_sat (
    .sum (s1_sum_r),
    .sh  (s1_sh_r),
    .x   (rs_x_s),
    .sat (rs_sat_s)
  );

  // Stage 1: capture the widened sum, clamped shift and last flag on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_sum_r   <= '0;
      s1_sh_r    <= 5'd0;
      s1_last_r  <= 1'b0;
    end else if (s1_load_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_sum_r  <= sum_s;
        s1_sh_r   <= eff_shift(cfg_shift);
        s1_last_r <= in_last;
      end
    end
  end

  // Stage 2: register the saturated result; held while downstream stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_r <= 1'b0;
      out_x      <= 8'd0;
      out_last   <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_x    <= rs_x_s;
        out_last <= s1_last_r;
      end
    end
  end

  // Saturation event counter: clear wins, sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (sat_inc_s && (sat_count != {CNT_W{1'b1}})) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_act_requant_q35.sv
// Scoreboard bench for act_requant_q35: driver pushes expected beats, monitor pops on transfer.
module tb_act_requant_q35;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_acc;
  logic        in_last;
  logic [4:0]  cfg_shift;
  logic [23:0] cfg_bias;
  logic        sat_clr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_x;
  logic        out_last;
  logic [15:0] sat_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_out = 0;
  int streak = 0;
  int last_streak = 0;
  bit lat_arm = 0;
  int acc_cyc0 = -1;
  logic [8:0] sb[$];

  act_requant_q35 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_acc(in_acc), .in_last(in_last), .cfg_shift(cfg_shift), .cfg_bias(cfg_bias),
    .sat_clr(sat_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_last(out_last), .sat_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every transferred beat against the scoreboard head.
  always @(negedge clk) begin
    if (reset && out_valid) streak = streak + 1;
    else begin
      if (streak > 0) last_streak = streak;
      streak = 0;
    end
    if (lat_arm && acc_cyc0 >= 0 && out_valid) begin
      chk("latency", cyc - acc_cyc0, 2);
      lat_arm = 0;
    end
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_beat", $signed(out_x), 999);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("out_x", $signed(out_x), $signed(e[7:0]));
        chk("out_last", int'(out_last), int'(e[8]));
        n_out++;
      end
    end
  end

  task automatic send(input int acc, input int bias, input int sh, input bit last, input int exp_x);
    bit got;
    int waited;
    in_acc = 24'(acc); cfg_bias = 24'(bias); cfg_shift = 5'(sh);
    in_last = last; in_valid = 1'b1;
    sb.push_back({last, 8'(exp_x)});
    got = 0; waited = 0;
    while (!got && waited < 100) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        if (lat_arm && acc_cyc0 < 0) acc_cyc0 = cyc;
      end else waited++;
    end
    if (!got) begin
      chk("send_timeout", 0, 1);
      void'(sb.pop_back());
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    repeat (2) @(posedge clk); #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int nacc;
    int base_out;
    bit have_hold;
    bit done;
    logic [7:0] hold;
    reset = 1'b0; in_valid = 1'b0; in_acc = '0; in_last = 1'b0;
    cfg_shift = 5'd0; cfg_bias = '0; sat_clr = 1'b0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_x", int'(out_x), 0);
    chk("rst_sat_count", int'(sat_count), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Rounding, half-up toward +inf
    send(640, 0, 6, 0, 10);
    send(96, 0, 6, 0, 2);
    send(-96, 0, 6, 0, -1);
    send(32, 0, 6, 0, 1);
    send(-32, 0, 6, 0, 0);
    idle(); drain();
    chk("sat_count_round", int'(sat_count), 0);

    // Saturation and the boundary values that are not flagged
    send(100000, 0, 6, 0, 127);
    send(-100000, 0, 6, 0, -128);
    send(-8192, 0, 6, 0, -128);
    send(8128, 0, 6, 0, 127);
    idle(); drain();
    chk("sat_count_two", int'(sat_count), 2);
    send(100000, 0, 6, 0, 127);
    idle();
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    drain();
    chk("sat_clr_priority", int'(sat_count), 0);

    // Shift and bias edges
    send(-3, 0, 0, 0, -3);
    send(24'h7FFFFF, 0, 20, 0, 127);
    send(640, -640, 6, 0, 0);
    idle(); drain();
    chk("sat_count_shift_clamp", int'(sat_count), 1);

    // Latency and full throughput
    last_streak = 0; acc_cyc0 = -1; lat_arm = 1;
    for (int k = 0; k < 8; k++) send(k * 32, 0, 5, (k == 7), k);
    idle(); drain();
    chk("latency_seen", int'(lat_arm), 0);
    chk("streak", last_streak, 8);

    // Backpressure: only two beats absorbed while the output is stalled
    base_out = n_out;
    out_ready = 1'b0; nacc = 0; have_hold = 0; hold = 8'd0;
    in_valid = 1'b1; cfg_shift = 5'd5; cfg_bias = '0; in_last = 1'b0;
    in_acc = 24'(20 * 32);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back({1'b0, 8'(20 + nacc)});
        nacc++;
      end
      if (out_valid) begin
        if (!have_hold) begin hold = out_x; have_hold = 1; end
        else chk("stall_stable", int'(out_x), int'(hold));
      end
      @(posedge clk); #1;
      in_acc = 24'((20 + nacc) * 32);
    end
    chk("bp_accepts", nacc, 2);
    chk("bp_in_ready", int'(in_ready), 0);
    idle();
    done = 0;
    fork
      begin
        for (int k = 0; k < 10; k++) send((30 + k) * 32, 0, 5, (k == 9), 30 + k);
        idle();
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("bp_delivered", n_out - base_out, 12);

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(50 * 32, 0, 5, 0, 50);
    send(51 * 32, 0, 5, 0, 51);
    idle();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    sb.delete();
    @(negedge clk); @(negedge clk);
    reset = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out_valid", int'(out_valid), 0);
    acc_cyc0 = -1; lat_arm = 1;
    send(5 * 32, 0, 5, 1, 5);
    idle(); drain();
    chk("post_rst_latency_seen", int'(lat_arm), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
